// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction stream in, decoded immediate stream out.
// The master modport is the environment side (producer of instructions and consumer of
// results); the slave modport is the decoder block itself.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_unknown;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_unknown
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_unknown
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator with a 2-entry skid buffer (output register + skid entry)
// and a saturating delivered-result counter.
// Optional macro IMM_ZICSR_EN: decode SYSTEM (1110011) CSR immediates (fmt 6 uimm, fmt 7 addr);
// when undefined, SYSTEM opcodes are reported as unknown.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  imm_gen_pipe_if.slave    bus,
  output logic [CNT_W-1:0] decode_cnt
);

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
`ifdef IMM_ZICSR_EN
  localparam logic [2:0] FmtZ    = 3'd6;
  localparam logic [2:0] FmtC    = 3'd7;
`endif

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_unk;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [2:0]      out_fmt_q, out_fmt_d;
  logic            out_unk_q, out_unk_d;

  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [2:0]      skid_fmt_q, skid_fmt_d;
  logic            skid_unk_q, skid_unk_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept, deliver;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];

  // Raw 32-bit immediates; widened to XLEN by sign extension in the decoder.
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Combinational decode of the presented instruction.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FmtNone;
    dec_unk = 1'b0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec_imm = XLEN'($signed(imm_i));
        dec_fmt = FmtI;
      end
      7'b0011011: begin
        // OP-IMM-32 only exists on RV64
        if (XLEN == 64) begin
          dec_imm = XLEN'($signed(imm_i));
          dec_fmt = FmtI;
        end else begin
          dec_unk = 1'b1;
        end
      end
      7'b0100011: begin
        dec_imm = XLEN'($signed(imm_s));
        dec_fmt = FmtS;
      end
      7'b1100011: begin
        dec_imm = XLEN'($signed(imm_b));
        dec_fmt = FmtB;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm = XLEN'($signed(imm_u));
        dec_fmt = FmtU;
      end
      7'b1101111: begin
        dec_imm = XLEN'($signed(imm_j));
        dec_fmt = FmtJ;
      end
      7'b0110011: begin
        // R-type: legitimately has no immediate
        dec_fmt = FmtNone;
      end
`ifdef IMM_ZICSR_EN
      7'b1110011: begin
        if (instr[14]) begin
          dec_imm = XLEN'(instr[19:15]);
          dec_fmt = FmtZ;
        end else if (instr[13:12] != 2'b00) begin
          dec_imm = XLEN'(instr[31:20]);
          dec_fmt = FmtC;
        end
      end
`endif
      default: dec_unk = 1'b1;
    endcase
  end

  // in_ready is the registered "skid entry empty" flag, so it never depends on out_ready.
  assign bus.in_ready = ~skid_valid_q;
  assign accept       = bus.in_valid & ~skid_valid_q & ~flush;
  assign deliver      = out_valid_q & bus.out_ready;

  // Skid-buffer and counter next-state.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_unk_d    = out_unk_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_unk_d   = skid_unk_q;
    cnt_d        = cnt_q;

    if (deliver && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || deliver) begin
      // Output register is free this cycle; skid holds the older entry if occupied.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_unk_d    = skid_unk_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_fmt_d   = dec_fmt;
        out_unk_d   = dec_unk;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new result in the skid entry.
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_unk_d   = dec_unk;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FmtNone;
      out_unk_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FmtNone;
      skid_unk_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_unk_q    <= out_unk_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_unk_q   <= skid_unk_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_unknown = out_unk_q;
  assign decode_cnt      = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an RV32 instance (16-bit counter) and an RV64 instance
// (2-bit counter) driven from one linear stimulus sequence.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int failures = 0;

  imm_gen_pipe_if #(.XLEN(32)) ia ();
  imm_gen_pipe_if #(.XLEN(64)) ib ();

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush_a),
    .bus        (ia.slave),
    .decode_cnt (cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush_b),
    .bus        (ib.slave),
    .decode_cnt (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    ia.in_valid = 1'b0; ia.in_instr = '0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.in_instr = '0; ib.out_ready = 1'b0;

    // Reset values
    #2;
    check("rst_in_ready",  64'(ia.in_ready), 64'd1);
    check("rst_out_valid", 64'(ia.out_valid), 64'd0);
    check("rst_out_imm",   64'(ia.out_imm), 64'd0);
    check("rst_out_fmt",   64'(ia.out_fmt), 64'd0);
    check("rst_out_unk",   64'(ia.out_unknown), 64'd0);
    check("rst_cnt",       64'(cnt_a), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // RV32 streaming: addi -1, sw -4, beq -8 on consecutive cycles
    ia.out_ready = 1'b1;
    ia.in_valid = 1'b1; ia.in_instr = 32'hFFF00093;
    tick();
    check("addi_valid", 64'(ia.out_valid), 64'd1);
    check("addi_imm",   64'(ia.out_imm), 64'hFFFFFFFF);
    check("addi_fmt",   64'(ia.out_fmt), 64'd1);
    ia.in_instr = 32'hFE112E23;
    tick();
    check("sw_imm", 64'(ia.out_imm), 64'hFFFFFFFC);
    check("sw_fmt", 64'(ia.out_fmt), 64'd2);
    ia.in_instr = 32'hFE000CE3;
    tick();
    check("beq_imm",   64'(ia.out_imm), 64'hFFFFFFF8);
    check("beq_fmt",   64'(ia.out_fmt), 64'd3);
    check("beq_valid", 64'(ia.out_valid), 64'd1);
    ia.in_valid = 1'b0;
    tick();
    check("stream_drained", 64'(ia.out_valid), 64'd0);
    check("stream_cnt",     64'(cnt_a), 64'd3);

    // lui on both widths, then addiw
    ia.in_valid = 1'b1; ia.in_instr = 32'h800000B7;
    ib.in_valid = 1'b1; ib.in_instr = 32'h800000B7; ib.out_ready = 1'b1;
    tick();
    check("lui64_imm", ib.out_imm, 64'hFFFFFFFF80000000);
    check("lui64_fmt", 64'(ib.out_fmt), 64'd4);
    check("lui32_imm", 64'(ia.out_imm), 64'h80000000);
    ia.in_instr = 32'h0000001B;
    ib.in_instr = 32'h0000001B;
    tick();
    check("addiw64_imm", ib.out_imm, 64'd0);
    check("addiw64_fmt", 64'(ib.out_fmt), 64'd1);
    check("addiw64_unk", 64'(ib.out_unknown), 64'd0);
    check("addiw32_unk", 64'(ia.out_unknown), 64'd1);
    check("addiw32_fmt", 64'(ia.out_fmt), 64'd0);
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
    tick();
    check("cnt_b_after_lui", 64'(cnt_b), 64'd2);

    // Backpressure: three instructions offered with out_ready low
    ia.out_ready = 1'b0;
    ia.in_valid = 1'b1; ia.in_instr = 32'h00500093;
    tick();
    check("bp_first_valid", 64'(ia.out_valid), 64'd1);
    check("bp_first_imm",   64'(ia.out_imm), 64'd5);
    check("bp_ready_1",     64'(ia.in_ready), 64'd1);
    ia.in_instr = 32'h00A00113;
    tick();
    check("bp_ready_2", 64'(ia.in_ready), 64'd0);
    check("bp_hold_1",  64'(ia.out_imm), 64'd5);
    ia.in_instr = 32'h00F00193;
    tick();
    check("bp_ready_3", 64'(ia.in_ready), 64'd0);
    check("bp_hold_2",  64'(ia.out_imm), 64'd5);
    check("bp_hold_v",  64'(ia.out_valid), 64'd1);
    ia.out_ready = 1'b1;
    tick();
    check("bp_drain_1", 64'(ia.out_imm), 64'd10);
    check("bp_ready_4", 64'(ia.in_ready), 64'd1);
    tick();
    check("bp_drain_2", 64'(ia.out_imm), 64'd15);
    ia.in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(ia.out_valid), 64'd0);
    check("bp_cnt",   64'(cnt_a), 64'd8);

    // Flush with both entries full
    ia.out_ready = 1'b0;
    ia.in_valid = 1'b1; ia.in_instr = 32'h00100093;
    tick();
    ia.in_instr = 32'h00200093;
    tick();
    check("fl_full", 64'(ia.in_ready), 64'd0);
    flush_a = 1'b1; ia.in_instr = 32'h00300093;
    tick();
    check("fl_valid", 64'(ia.out_valid), 64'd0);
    check("fl_ready", 64'(ia.in_ready), 64'd1);
    flush_a = 1'b0; ia.in_valid = 1'b0; ia.out_ready = 1'b1;
    tick();
    check("fl_stays_empty", 64'(ia.out_valid), 64'd0);

    // Flush with delivery and an acceptable instruction in the same cycle
    ia.out_ready = 1'b0;
    ia.in_valid = 1'b1; ia.in_instr = 32'h00400093;
    tick();
    flush_a = 1'b1; ia.out_ready = 1'b1; ia.in_instr = 32'h00500093;
    tick();
    check("fl2_valid", 64'(ia.out_valid), 64'd0);
    check("fl2_ready", 64'(ia.in_ready), 64'd1);
    check("fl2_cnt",   64'(cnt_a), 64'd9);
    flush_a = 1'b0; ia.in_valid = 1'b0;
    tick();
    check("fl2_dropped", 64'(ia.out_valid), 64'd0);

    // CSR immediate, unknown opcode, R-type, jal, auipc
    ia.in_valid = 1'b1; ia.in_instr = 32'h3002D073;
    tick();
`ifdef IMM_ZICSR_EN
    check("csr_imm", 64'(ia.out_imm), 64'd5);
    check("csr_fmt", 64'(ia.out_fmt), 64'd6);
    check("csr_unk", 64'(ia.out_unknown), 64'd0);
`else
    check("csr_imm", 64'(ia.out_imm), 64'd0);
    check("csr_fmt", 64'(ia.out_fmt), 64'd0);
    check("csr_unk", 64'(ia.out_unknown), 64'd1);
`endif
    ia.in_instr = 32'h0000007F;
    tick();
    check("op7f_unk", 64'(ia.out_unknown), 64'd1);
    check("op7f_fmt", 64'(ia.out_fmt), 64'd0);
    check("op7f_imm", 64'(ia.out_imm), 64'd0);
    ia.in_instr = 32'h002081B3;
    tick();
    check("add_unk", 64'(ia.out_unknown), 64'd0);
    check("add_fmt", 64'(ia.out_fmt), 64'd0);
    ia.in_instr = 32'h0080006F;
    tick();
    check("jal_imm", 64'(ia.out_imm), 64'd8);
    check("jal_fmt", 64'(ia.out_fmt), 64'd5);
    ia.in_instr = 32'h12345017;
    tick();
    check("auipc_imm", 64'(ia.out_imm), 64'h12345000);
    check("auipc_fmt", 64'(ia.out_fmt), 64'd4);
    ia.in_valid = 1'b0;
    tick();
    check("misc_cnt", 64'(cnt_a), 64'd14);

    // Fresh reset, then saturate the 2-bit counter
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ib.out_ready = 1'b1;
    ib.in_valid = 1'b1; ib.in_instr = 32'h00100093;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_cnt_%0d", i), 64'(cnt_b), 64'(sat_exp[i]));
    end
    ib.in_valid = 1'b0;
    tick();

    // Stall with two entries, then assert reset between clock edges
    ib.out_ready = 1'b0;
    ib.in_valid = 1'b1; ib.in_instr = 32'hFFF00093;
    tick();
    tick();
    check("stall_ready", 64'(ib.in_ready), 64'd0);
    check("stall_valid", 64'(ib.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(ib.out_valid), 64'd0);
    check("async_ready", 64'(ib.in_ready), 64'd1);
    check("async_imm",   ib.out_imm, 64'd0);
    check("async_cnt",   64'(cnt_b), 64'd0);
    ib.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
